// File: rtl/pipeline_pkg.sv
// Shared types and default widths for the Execute/Memory pipeline register.
package pipeline_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 4;

  // Occupancy is encoded directly in the state value (0, 1 or 2 entries).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } em_state_t;

  // Default-width view of one slot, in the same bit order as the flat slot vector.
  typedef struct packed {
    logic                  wbs;
    logic                  wme;
    logic                  mm;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [DATA_W_DEF-1:0] write_data;
    logic [REG_W_DEF-1:0]  rd;
  } em_payload_t;

endpackage

// File: rtl/em_payload_reg.sv
// Enable-loaded payload register with asynchronous clear; one instance per slot.
module em_payload_reg
  import pipeline_pkg::*;
#(
  parameter int W = $bits(em_payload_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load on enable, clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/execute_memory_register.sv
// Execute->Memory pipeline register: 2-entry skid buffer so in_ready is a pure
// function of the state flop and never of out_ready.
module execute_memory_register
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wbs_in,
  input  logic              wme_in,
  input  logic              mm_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] write_data_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wbs_out,
  output logic              wme_out,
  output logic              mm_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] write_data_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [1:0]        occupancy
);

  localparam int PW = 3 + 2*DATA_W + REG_W;

  em_state_t       state;
  logic [PW-1:0]   in_pay, main_d, main_q, skid_q;
  logic            accept, consume, main_en, skid_en;
  logic            main_wbs, main_wme;

  assign in_pay    = {wbs_in, wme_in, mm_in, alu_result_in, write_data_in, rd_in};
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // Slot load control: main refills from skid when draining FULL, otherwise from input.
  always_comb begin
    main_d  = (state == FULL) ? skid_q : in_pay;
    main_en = 1'b0;
    skid_en = 1'b0;
    if (!flush) begin
      unique case (state)
        EMPTY:   main_en = accept;
        ONE: begin
          main_en = accept & consume;
          skid_en = accept & ~consume;
        end
        FULL:    main_en = consume;
        default: ;
      endcase
    end
  end

  // Occupancy state; flush overrides any accept/consume in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state <= EMPTY;
    else if (flush) state <= EMPTY;
    else begin
      unique case (state)
        EMPTY:   if (accept) state <= ONE;
        ONE:     if (accept & ~consume) state <= FULL;
                 else if (~accept & consume) state <= EMPTY;
        FULL:    if (consume) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  em_payload_reg #(.W(PW)) u_main (
    .clk (clk), .rst (rst), .en (main_en), .d (main_d), .q (main_q)
  );

  em_payload_reg #(.W(PW)) u_skid (
    .clk (clk), .rst (rst), .en (skid_en), .d (in_pay), .q (skid_q)
  );

  assign {main_wbs, main_wme, mm_out, alu_result_out, write_data_out, rd_out} = main_q;

  // Side-effecting controls are masked during bubbles so a stale slot cannot write.
  assign wbs_out = main_wbs & out_valid;
  assign wme_out = main_wme & out_valid;

endmodule

// File: tb/tb_execute_memory_register.sv
// Directed bench with a scoreboard queue for the Execute/Memory skid register.
module tb_execute_memory_register;

  typedef struct packed {
    logic        wbs;
    logic        wme;
    logic        mm;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [3:0]  rd;
  } pay_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic        wbs_in, wme_in, mm_in;
  logic [31:0] alu_result_in, write_data_in;
  logic [3:0]  rd_in;
  logic        out_valid, out_ready;
  logic        wbs_out, wme_out, mm_out;
  logic [31:0] alu_result_out, write_data_out;
  logic [3:0]  rd_out;
  logic [1:0]  occupancy;

  int   n_assert = 0;
  int   n_fail   = 0;
  pay_t sb[$];

  always #5 clk = ~clk;

  execute_memory_register #(.DATA_W(32), .REG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wbs_out(wbs_out), .wme_out(wme_out), .mm_out(mm_out),
    .alu_result_out(alu_result_out), .write_data_out(write_data_out), .rd_out(rd_out),
    .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic e, input logic m,
                       input logic [31:0] a, input logic [31:0] w, input logic [3:0] r);
    in_valid = v; wbs_in = b; wme_in = e; mm_in = m;
    alu_result_in = a; write_data_in = w; rd_in = r;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD, 32'hBEEF, 4'hF);
  endtask

  // Compare outputs against the scoreboard head, advance the model, then clock.
  task automatic cycle();
    int   cnt;
    pay_t h;
    logic acc, cons;
    cnt = sb.size();
    chk("occupancy", {30'b0, occupancy}, cnt);
    chk("in_ready", {31'b0, in_ready}, {31'b0, cnt != 2});
    chk("out_valid", {31'b0, out_valid}, {31'b0, cnt != 0});
    if (cnt == 0) begin
      chk("wbs_bubble", {31'b0, wbs_out}, 32'd0);
      chk("wme_bubble", {31'b0, wme_out}, 32'd0);
    end else begin
      h = sb[0];
      chk("wbs_out", {31'b0, wbs_out}, {31'b0, h.wbs});
      chk("wme_out", {31'b0, wme_out}, {31'b0, h.wme});
      chk("mm_out", {31'b0, mm_out}, {31'b0, h.mm});
      chk("alu_result_out", alu_result_out, h.alu);
      chk("write_data_out", write_data_out, h.wd);
      chk("rd_out", {28'b0, rd_out}, {28'b0, h.rd});
    end
    acc  = in_valid && (cnt != 2);
    cons = (cnt != 0) && out_ready;
    if (flush) sb.delete();
    else begin
      if (cons) void'(sb.pop_front());
      if (acc)  sb.push_back({wbs_in, wme_in, mm_in, alu_result_in, write_data_in, rd_in});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_wbs", {31'b0, wbs_out}, 32'd0);
    chk("rst_wme", {31'b0, wme_out}, 32'd0);
    chk("rst_occ", {30'b0, occupancy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_alu", alu_result_out, 32'd0);
    chk("rst_rd", {28'b0, rd_out}, 32'd0);
    rst = 1'b0;

    // Single pass
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h1234, 4'd3);
    cycle();
    idle();
    repeat (2) cycle();

    // Back-pressure: A then B held, drained in order
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h1, 32'hA0, 4'd1); cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h2, 32'hB0, 4'd2); cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h3, 32'hC0, 4'd7); cycle();
    idle(); cycle();
    out_ready = 1'b1;
    repeat (3) cycle();

    // Streaming 8 back-to-back
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i[0], i[1], i[2], i, 32'h100 + i, i[3:0]);
      cycle();
    end
    idle();
    repeat (2) cycle();

    // Flush while FULL with a simultaneous input
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h55, 32'h5, 4'd5); cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h66, 32'h6, 4'd6); cycle();
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h99, 32'h9, 4'd9); cycle();
    flush = 1'b0;
    idle(); out_ready = 1'b1;
    repeat (2) cycle();

    // Async reset between edges while FULL
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h77, 32'h7, 4'd7); cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h88, 32'h8, 4'd8); cycle();
    idle();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_occ", {30'b0, occupancy}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_wme", {31'b0, wme_out}, 32'd0);
    chk("arst_alu", alu_result_out, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hA00 + i, 32'h0, 4'(i + 1));
      cycle();
    end
    idle();
    repeat (2) cycle();

    // Random valid/ready mix
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, 4'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    idle(); out_ready = 1'b1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
